mem_access_unit: RTL and testbench

Memory-stage engine sitting directly downstream of the EX/MEM pipeline register. It consumes the EX/MEM control bits (memRead, memWrite, word, regWrite), ALU result, store data and destination register. It performs byte or word loads and stores over a request/ready data-memory handshake, stalling the front of the pipeline while an access is outstanding. It also owns the MEM/WB pipeline register that feeds writeback.

---
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 tb/tb_mem_access_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory stage: issues byte/word loads and stores over a req/ready handshake,
// stalls the front of the pipeline while an access is outstanding, and owns MEM/WB.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              inMemRead,
  input  logic              inMemWrite,
  input  logic              inWord,
  input  logic              inRegWrite,
  input  logic [31:0]       inResult,
  input  logic [31:0]       inReadData2,
  input  logic [4:0]        inRd,
  output logic              dmReq,
  output logic              dmWe,
  output logic [ADDR_W-1:0] dmAddr,
  output logic [31:0]       dmWdata,
  output logic [3:0]        dmByteEn,
  input  logic              dmReady,
  input  logic [31:0]       dmRdata,
  output logic              stall,
  output logic              outRegWrite,
  output logic [4:0]        outRd,
  output logic [31:0]       outWriteData,
  output logic              outMisaligned
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic              dm_req_q, dm_req_d;
  logic              dm_we_q, dm_we_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [31:0]       dm_wdata_q, dm_wdata_d;
  logic [3:0]        dm_be_q, dm_be_d;
  logic [31:0]       load_q, load_d;
  logic              out_rw_q, out_rw_d;
  logic [4:0]        out_rd_q, out_rd_d;
  logic [31:0]       out_wd_q, out_wd_d;
  logic              out_mis_q, out_mis_d;

  logic        mem_op, misaligned, issue;
  logic [7:0]  lane_byte;
  logic [31:0] load_word;

  assign mem_op     = inMemRead | inMemWrite;
  assign misaligned = mem_op & inWord & (inResult[1:0] != 2'b00);
  assign issue      = (state_q == IDLE) & mem_op & ~misaligned;
  assign stall      = issue | (state_q == BUSY);

  // Byte loads pick the lane addressed by the latched request (little-endian).
  always_comb begin
    lane_byte = dmRdata[7:0];
    case (dm_addr_q[1:0])
      2'd0: lane_byte = dmRdata[7:0];
      2'd1: lane_byte = dmRdata[15:8];
      2'd2: lane_byte = dmRdata[23:16];
      2'd3: lane_byte = dmRdata[31:24];
      default: lane_byte = dmRdata[7:0];
    endcase
    load_word = inWord ? dmRdata : {{24{lane_byte[7]}}, lane_byte};
  end

  always_comb begin
    state_d    = state_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    dm_be_d    = dm_be_q;
    load_d     = load_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          dm_req_d   = 1'b1;
          dm_we_d    = inMemWrite;
          dm_addr_d  = inResult[ADDR_W-1:0];
          dm_wdata_d = inWord ? inReadData2 : {4{inReadData2[7:0]}};
          dm_be_d    = inWord ? 4'hF : (4'b0001 << inResult[1:0]);
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (dmReady) begin
          dm_req_d = 1'b0;
          load_d   = load_word;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // MEM/WB: bubble while stalled; stores and misaligned ops never write a register.
  always_comb begin
    out_rd_d  = out_rd_q;
    out_wd_d  = out_wd_q;
    out_rw_d  = 1'b0;
    out_mis_d = misaligned & (state_q == IDLE);
    if (!stall) begin
      out_rd_d = inRd;
      out_rw_d = inRegWrite & ~misaligned & ~inMemWrite;
      out_wd_d = inMemRead ? load_q : inResult;
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q    <= IDLE;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      dm_be_q    <= '0;
      load_q     <= '0;
      out_rw_q   <= 1'b0;
      out_rd_q   <= '0;
      out_wd_q   <= '0;
      out_mis_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      dm_be_q    <= dm_be_d;
      load_q     <= load_d;
      out_rw_q   <= out_rw_d;
      out_rd_q   <= out_rd_d;
      out_wd_q   <= out_wd_d;
      out_mis_q  <= out_mis_d;
    end
  end

  assign dmReq         = dm_req_q;
  assign dmWe          = dm_we_q;
  assign dmAddr        = dm_addr_q;
  assign dmWdata       = dm_wdata_q;
  assign dmByteEn      = dm_be_q;
  assign outRegWrite   = out_rw_q;
  assign outRd         = out_rd_q;
  assign outWriteData  = out_wd_q;
  assign outMisaligned = out_mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Table-driven bench for mem_access_unit with a writeback scoreboard and a
// latency-programmable memory responder, plus a reset-during-BUSY sequence.
module tb_mem_access_unit;

  logic        clock, nreset;
  logic        inMemRead, inMemWrite, inWord, inRegWrite;
  logic [31:0] inResult, inReadData2;
  logic [4:0]  inRd;
  logic        dmReq, dmWe;
  logic [31:0] dmAddr, dmWdata;
  logic [3:0]  dmByteEn;
  logic        dmReady;
  logic [31:0] dmRdata;
  logic        stall, outRegWrite, outMisaligned;
  logic [4:0]  outRd;
  logic [31:0] outWriteData;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clock(clock), .nreset(nreset),
    .inMemRead(inMemRead), .inMemWrite(inMemWrite), .inWord(inWord),
    .inRegWrite(inRegWrite), .inResult(inResult), .inReadData2(inReadData2),
    .inRd(inRd), .dmReq(dmReq), .dmWe(dmWe), .dmAddr(dmAddr),
    .dmWdata(dmWdata), .dmByteEn(dmByteEn), .dmReady(dmReady),
    .dmRdata(dmRdata), .stall(stall), .outRegWrite(outRegWrite),
    .outRd(outRd), .outWriteData(outWriteData), .outMisaligned(outMisaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        mr, mw, word, rw;
    logic [31:0] res, d2;
    logic [4:0]  rd;
    int          lat;
    logic [31:0] rdata;
    logic        e_rw;
    logic [31:0] e_data;
    logic        e_mis;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
  } vec_t;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_nop();
    inMemRead = 0; inMemWrite = 0; inWord = 0; inRegWrite = 0;
    inResult = 0; inReadData2 = 0; inRd = 0;
  endtask

  task automatic exec(input int idx, input vec_t v);
    exp_t e, got;
    logic is_mem, retire;
    int   stall_cnt, req_cnt, b;
    stall_cnt = 0; req_cnt = 0; b = 0; retire = 0;
    is_mem = (v.mr | v.mw) & ~v.e_mis;
    @(negedge clock);
    inMemRead = v.mr; inMemWrite = v.mw; inWord = v.word; inRegWrite = v.rw;
    inResult = v.res; inReadData2 = v.d2; inRd = v.rd;
    dmRdata = v.rdata;
    e.rw = v.e_rw; e.rd = v.rd; e.data = v.e_data; e.mis = v.e_mis;
    sb.push_back(e);
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc != 0) @(negedge clock);
      #1;
      if (stall) stall_cnt++;
      if (dmReq) begin
        req_cnt++;
        chk("dmAddr", dmAddr, v.res);
        chk("dmWe", {31'd0, dmWe}, {31'd0, v.mw});
        chk("dmByteEn", {28'd0, dmByteEn}, {28'd0, v.e_be});
        chk("dmWdata", dmWdata, v.e_wd);
        dmReady = (b == v.lat);
        b++;
      end else begin
        dmReady = 1'b0;
      end
      retire = ~stall;
      @(posedge clock);
      #1;
      if (retire) break;
      chk("bubble_rw", {31'd0, outRegWrite}, 32'd0);
      chk("bubble_mis", {31'd0, outMisaligned}, 32'd0);
    end
    dmReady = 1'b0;
    if (!retire) chk("retire_timeout", 32'd0, 32'd1);
    chk("stall_cycles", stall_cnt, is_mem ? v.lat + 2 : 0);
    chk("req_cycles", req_cnt, is_mem ? v.lat + 1 : 0);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk("outRegWrite", {31'd0, outRegWrite}, {31'd0, got.rw});
      chk("outMisaligned", {31'd0, outMisaligned}, {31'd0, got.mis});
      if (got.rw) begin
        chk("outRd", {27'd0, outRd}, {27'd0, got.rd});
        chk("outWriteData", outWriteData, got.data);
      end
    end
    $display("instr %0d: mr=%0b mw=%0b word=%0b addr=0x%08h lat=%0d stall=%0d req=%0d wb_rw=%0b wb=0x%08h mis=%0b",
             idx, v.mr, v.mw, v.word, v.res, v.lat, stall_cnt, req_cnt,
             outRegWrite, outWriteData, outMisaligned);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_dmReq"}, {31'd0, dmReq}, 32'd0);
    chk({tag, "_dmWe"}, {31'd0, dmWe}, 32'd0);
    chk({tag, "_dmAddr"}, dmAddr, 32'd0);
    chk({tag, "_dmWdata"}, dmWdata, 32'd0);
    chk({tag, "_dmByteEn"}, {28'd0, dmByteEn}, 32'd0);
    chk({tag, "_outRegWrite"}, {31'd0, outRegWrite}, 32'd0);
    chk({tag, "_outRd"}, {27'd0, outRd}, 32'd0);
    chk({tag, "_outWriteData"}, outWriteData, 32'd0);
    chk({tag, "_outMisaligned"}, {31'd0, outMisaligned}, 32'd0);
  endtask

  initial begin
    //            mr mw wd rw  res           d2            rd  lat rdata         e_rw e_data        mis  be     wd
    vecs[0]  = '{0, 0, 0, 1, 32'h00001234, 32'h0,        5,  0, 32'h0,        1, 32'h00001234, 0, 4'h0, 32'h0};
    vecs[1]  = '{1, 0, 1, 1, 32'h00000100, 32'h11111111, 7,  2, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 4'hF, 32'h11111111};
    vecs[2]  = '{1, 0, 0, 1, 32'h00000103, 32'h00000055, 8,  1, 32'h80FF0011, 1, 32'hFFFFFF80, 0, 4'h8, 32'h55555555};
    vecs[3]  = '{0, 1, 0, 1, 32'h00000201, 32'h000000AB, 9,  1, 32'h0,        0, 32'h0,        0, 4'h2, 32'hABABABAB};
    vecs[4]  = '{1, 0, 1, 1, 32'h00000102, 32'h0,        10, 0, 32'h0,        0, 32'h0,        1, 4'h0, 32'h0};
    vecs[5]  = '{0, 1, 1, 0, 32'h00000300, 32'hCAFEF00D, 0,  0, 32'h0,        0, 32'h0,        0, 4'hF, 32'hCAFEF00D};
    vecs[6]  = '{1, 0, 0, 1, 32'h00000102, 32'h00000012, 11, 0, 32'h007F0000, 1, 32'h0000007F, 0, 4'h4, 32'h12121212};
    vecs[7]  = '{1, 0, 0, 1, 32'h00000100, 32'h0,        12, 3, 32'h000000C3, 1, 32'hFFFFFFC3, 0, 4'h1, 32'h0};
    vecs[8]  = '{1, 0, 1, 1, 32'h00000104, 32'h0,        13, 0, 32'h12345678, 1, 32'h12345678, 0, 4'hF, 32'h0};
    vecs[9]  = '{0, 0, 0, 0, 32'h00000055, 32'h0,        3,  0, 32'h0,        0, 32'h0,        0, 4'h0, 32'h0};
    vecs[10] = '{0, 1, 1, 1, 32'h00000203, 32'h0,        14, 0, 32'h0,        0, 32'h0,        1, 4'h0, 32'h0};

    nreset = 1'b0; dmReady = 1'b0; dmRdata = 32'h0;
    drive_nop();
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");
    chk("reset_stall", {31'd0, stall}, 32'd0);
    @(negedge clock);
    nreset = 1'b1;

    for (int i = 0; i < 11; i++) exec(i, vecs[i]);

    // Reset while BUSY: the request drops and a late dmReady is ignored.
    @(negedge clock);
    inMemRead = 1; inMemWrite = 0; inWord = 1; inRegWrite = 1;
    inResult = 32'h00000100; inRd = 5'd6; dmRdata = 32'hA5A5A5A5;
    repeat (3) @(negedge clock);
    #1;
    chk("busy_req", {31'd0, dmReq}, 32'd1);
    @(negedge clock);
    nreset = 1'b0;
    drive_nop();
    @(posedge clock);
    #1;
    check_all_zero("rst_busy");
    @(negedge clock);
    nreset = 1'b1;
    dmReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("post_rst_stall", {31'd0, stall}, 32'd0);
      @(posedge clock);
      #1;
      chk("post_rst_req", {31'd0, dmReq}, 32'd0);
      chk("post_rst_rw", {31'd0, outRegWrite}, 32'd0);
      @(negedge clock);
    end
    dmReady = 1'b0;
    $display("instr reset_in_busy: dmReq=%0b stall=%0b wb_rw=%0b", dmReq, stall, outRegWrite);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
